// File: rtl/vram_port_arbiter_if.sv
// vram_port_arbiter_if
//   Bundles the two requester handshakes (A = MemoryUnit, B = blitter/DMA)
//   and the VRAM cpu_* port that the arbiter drives.
//   Ports per requester x in {a,b}:
//     x_req/x_we/x_addr/x_d  requester -> arbiter, held until x_ack
//     x_ack                  one-cycle completion pulse
//     x_q                    read data, held until that requester's next completion
//   VRAM side: vram_addr/vram_d/vram_we -> RAM, vram_q <- RAM (1-cycle sync read)
//   Modports: master = requesters + RAM, slave = arbiter.
interface vram_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
);
  logic              a_req, a_we, a_ack;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_d, a_q;
  logic              b_req, b_we, b_ack;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_d, b_q;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_d, vram_q;
  logic              vram_we;

  modport master (
    output a_req, a_we, a_addr, a_d, b_req, b_we, b_addr, b_d, vram_q,
    input  a_ack, a_q, b_ack, b_q, vram_addr, vram_d, vram_we
  );

  modport slave (
    input  a_req, a_we, a_addr, a_d, b_req, b_we, b_addr, b_d, vram_q,
    output a_ack, a_q, b_ack, b_q, vram_addr, vram_d, vram_we
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter
//   Shares the single CPU-side port of one VRAM instance between requester A
//   (MemoryUnit) and requester B (blitter/DMA). One access at a time through
//   IDLE -> ISSUE -> CAPTURE -> ACK; ack arrives 3 cycles after the request is
//   sampled in IDLE, one access per 4 cycles.
//   Ports:
//     clk     system clock
//     nreset  synchronous active-low reset
//     bus     vram_port_arbiter_if.slave (requester handshakes + VRAM port)
//   Build option:
//     VRAM_ARB_FIXED_PRIO_EN  defined: A always wins contention, B only served
//                             in an IDLE cycle with a_req=0. Undefined (default):
//                             round-robin, strict A/B alternation under contention.

// Per-requester response register: captures read data and raises ack for one cycle.
module vram_arb_lane #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              cap,
  input  logic              fin,
  input  logic [DATA_W-1:0] rd,
  output logic              ack,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!nreset) begin
      ack <= 1'b0;
      q   <= '0;
    end else if (cap) begin
      ack <= 1'b1;
      q   <= rd;
    end else if (fin) begin
      ack <= 1'b0;
    end
  end
endmodule

module vram_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
) (
  input logic              clk,
  input logic              nreset,
  vram_port_arbiter_if.slave bus
);
  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_ACK} state_t;

  state_t state_q, state_d;

  logic              any_req, pick_b;
  logic              load, cap, fin;
  logic              gnt;        // 0 = A, 1 = B
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] d_q;
  logic              we_q;

  logic [NUM_PORTS-1:0]             lane_cap, lane_fin, ack_v;
  logic [NUM_PORTS-1:0][DATA_W-1:0] q_v;

  assign any_req = bus.a_req | bus.b_req;

`ifdef VRAM_ARB_FIXED_PRIO_EN
  assign pick_b = ~bus.a_req;
`else
  logic last_grant;  // 0 = A, 1 = B; reset to B so A wins the first tie
  assign pick_b = bus.b_req & (~bus.a_req | ~last_grant);

  always_ff @(posedge clk) begin
    if (!nreset)   last_grant <= 1'b1;
    else if (load) last_grant <= pick_b;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!nreset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (any_req) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_ACK;
      S_ACK:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Control strobes
  always_comb begin
    load = 1'b0;
    cap  = 1'b0;
    fin  = 1'b0;
    unique case (state_q)
      S_IDLE:    load = any_req;
      S_CAPTURE: cap  = 1'b1;
      S_ACK:     fin  = 1'b1;
      default:   ;
    endcase
  end

  // VRAM command registers; addr/d hold their last value while idle
  always_ff @(posedge clk) begin
    if (!nreset) begin
      addr_q <= '0;
      d_q    <= '0;
      we_q   <= 1'b0;
      gnt    <= 1'b0;
    end else if (load) begin
      addr_q <= pick_b ? bus.b_addr : bus.a_addr;
      d_q    <= pick_b ? bus.b_d    : bus.a_d;
      we_q   <= pick_b ? bus.b_we   : bus.a_we;
      gnt    <= pick_b;
    end else if (state_q == S_ISSUE) begin
      we_q   <= 1'b0;
    end
  end

  // Only the granted lane sees cap/fin, so the other lane's outputs never move
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    assign lane_cap[i] = cap & (gnt == 1'(i));
    assign lane_fin[i] = fin & (gnt == 1'(i));
    vram_arb_lane #(.DATA_W(DATA_W)) u_lane (
      .clk    (clk),
      .nreset (nreset),
      .cap    (lane_cap[i]),
      .fin    (lane_fin[i]),
      .rd     (bus.vram_q),
      .ack    (ack_v[i]),
      .q      (q_v[i])
    );
  end

  assign bus.vram_addr = addr_q;
  assign bus.vram_d    = d_q;
  assign bus.vram_we   = we_q;
  assign bus.a_ack     = ack_v[0];
  assign bus.a_q       = q_v[0];
  assign bus.b_ack     = ack_v[1];
  assign bus.b_q       = q_v[1];
endmodule

// File: tb/tb_vram_port_arbiter.sv
module tb_vram_port_arbiter;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #10 clk = ~clk;

  vram_port_arbiter_if #(.DATA_W(32), .ADDR_W(14)) bus ();

  vram_port_arbiter #(.DATA_W(32), .ADDR_W(14)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  // Behavioural VRAM: sync write, registered read (old data on same-cycle write)
  logic [31:0] mem [0:16383];
  always @(posedge clk) begin
    if (bus.vram_we) mem[bus.vram_addr] <= bus.vram_d;
    bus.vram_q <= mem[bus.vram_addr];
  end

  int n_chk = 0;
  int n_err = 0;
  int a_acks = 0;
  int b_acks = 0;
  int grants[$];

  always @(negedge clk) begin
    if (bus.a_ack) begin a_acks++; grants.push_back(0); end
    if (bus.b_ack) begin b_acks++; grants.push_back(1); end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for its ack (bounded), drop req, return in IDLE.
  task automatic access(input bit pb, input bit we, input logic [13:0] addr,
                        input logic [31:0] d, output int lat);
    logic ack;
    if (pb) begin bus.b_req = 1; bus.b_we = we; bus.b_addr = addr; bus.b_d = d; end
    else    begin bus.a_req = 1; bus.a_we = we; bus.a_addr = addr; bus.a_d = d; end
    lat = 0;
    do begin
      tick();
      lat++;
      ack = pb ? bus.b_ack : bus.a_ack;
    end while (!ack && lat < 12);
    if (!ack) chk("ack_timeout", 0, 1);
    if (pb) bus.b_req = 0; else bus.a_req = 0;
    tick();
  endtask

  task automatic do_reset();
    nreset = 0;
    tick(); tick();
    nreset = 1;
  endtask

  initial begin
    int lat;
    logic [7:0] seq;
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_d = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_d = '0;
    bus.vram_q = '0;
    do_reset();

    // Reset state
    chk("rst_we",   bus.vram_we, 0);
    chk("rst_addr", bus.vram_addr, 0);
    chk("rst_acks", {bus.a_ack, bus.b_ack}, 0);
    chk("rst_q",    {bus.a_q, bus.b_q}, 0);

    // Single write with cycle-accurate checks (cycle 0 = request sampled in IDLE)
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 14'h0010; bus.a_d = 32'hDEADBEEF;
    tick();
    chk("wr_c1_we",   bus.vram_we, 1);
    chk("wr_c1_addr", bus.vram_addr, 14'h0010);
    chk("wr_c1_d",    bus.vram_d, 32'hDEADBEEF);
    tick();
    chk("wr_c2_we",  bus.vram_we, 0);
    chk("wr_c2_ack", bus.a_ack, 0);
    tick();
    chk("wr_c3_ack", bus.a_ack, 1);
    bus.a_req = 0;
    tick();
    chk("wr_c4_ack", bus.a_ack, 0);
    chk("wr_hold_addr", bus.vram_addr, 14'h0010);

    access(0, 0, 14'h0010, 32'h0, lat);
    chk("rd_lat", lat, 3);
    chk("rd_q",   bus.a_q, 32'hDEADBEEF);

    // Contention after reset: A first, then strict alternation
    do_reset();
    grants.delete();
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 14'h0100; bus.a_d = 32'hA0;
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 14'h0200; bus.b_d = 32'hB0;
    tick();                                   // c1
    chk("ct_c1_addr", bus.vram_addr, 14'h0100);
    tick(); tick();                           // c3
    chk("ct_c3_ack", {bus.a_ack, bus.b_ack}, 2'b10);
    tick(); tick();                           // c5
    chk("ct_c5_we",   bus.vram_we, 1);
    chk("ct_c5_addr", bus.vram_addr, 14'h0200);
    tick(); tick();                           // c7
    chk("ct_c7_ack", {bus.a_ack, bus.b_ack}, 2'b01);
    repeat (24) tick();                       // c31: 8th ack
    bus.a_req = 0; bus.b_req = 0;
    tick();
    chk("ct_ngrants", grants.size(), 8);
    seq = '0;
    for (int i = 0; i < 8 && i < grants.size(); i++) seq[i] = grants[i][0];
    chk("ct_seq", seq, 8'hAA);  // bit i = 1 means grant i went to B

    // Put a known value into a_q for the isolation check
    access(0, 0, 14'h0010, 32'h0, lat);
    chk("pre_iso_q", bus.a_q, 32'hDEADBEEF);

    // Isolation: B write then read, A outputs untouched
    a_acks = 0;
    access(1, 1, 14'h0001, 32'h55, lat);
    access(1, 0, 14'h0001, 32'h0, lat);
    chk("iso_lat", lat, 3);
    chk("iso_bq",  bus.b_q, 32'h55);
    chk("iso_aq",  bus.a_q, 32'hDEADBEEF);
    chk("iso_aack", a_acks, 0);

    // Reset during CAPTURE of an A read
    a_acks = 0;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 14'h0010;
    tick(); tick();                           // c2 = CAPTURE
    nreset = 0;
    tick();
    chk("rmo_ack", bus.a_ack, 0);
    chk("rmo_aq",  bus.a_q, 0);
    chk("rmo_we",  bus.vram_we, 0);
    bus.a_req = 0;
    nreset = 1;
    tick();
    tick();
    chk("rmo_noack", a_acks, 0);
    access(1, 0, 14'h0001, 32'h0, lat);
    chk("rmo_b_lat", lat, 3);
    chk("rmo_b_q",   bus.b_q, 32'h55);

    // Idle hold
    a_acks = 0; b_acks = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle", {bus.vram_we, bus.a_ack, bus.b_ack}, 0);
    end
    chk("idle_addr", bus.vram_addr, 14'h0001);

`ifdef VRAM_ARB_FIXED_PRIO_EN
    // B held while A requests back-to-back: B waits until A idles
    b_acks = 0;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 14'h0001;
    for (int i = 0; i < 3; i++) begin
      access(0, 0, 14'h0010, 32'h0, lat);
      chk("fp_a_lat", lat, 3);
    end
    chk("fp_b_starved", b_acks, 0);
    lat = 0;
    do begin tick(); lat++; end while (!bus.b_ack && lat < 12);
    chk("fp_b_lat", lat, 3);
    bus.b_req = 0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
